// File: rtl/core_pio_out_pulse.sv
// core_pio_out_pulse
//
// Avalon-MM slave output PIO with atomic set/clear access, a hardware
// one-shot pulse engine and a maskable pulse-done interrupt.
//
// The pulse engine drives the pins in pulse_mask high for exactly
// pulse_len clk cycles, starting the cycle after the triggering write.
// A retrigger while a pulse is running ORs in the new pins and restarts
// the count. When the pulse expires, the engine sets the sticky done flag.
//
// Register map (word addresses):
//   0 DATA       W: out_reg = wd            R: out_reg
//   1 OUTSET     W: out_reg |= wd           R: out_reg
//   2 OUTCLR     W: out_reg &= ~wd          R: out_reg
//   3 PULSE_LEN  W: pulse_len = wd          R: pulse_len
//   4 PULSE      W: trigger pulse on wd     R: pulse_mask (0 when idle)
//   5 STATUS     W: clear done              R: {done, busy}
//   6 CONTROL    W: irq_en = wd[0]          R: irq_en
//   7 reserved   W: ignored                 R: 0
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   address      register word address
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     registered read data (1-cycle latency, no side effects)
//   irq          pulse-done interrupt (done & irq_en)
//   out_port     output pins (out_reg OR active pulse bits)

module core_pio_out_pulse #(
    parameter int               WIDTH       = 10,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_OUTSET    = 3'd1;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
    localparam logic [2:0] ADDR_CONTROL   = 3'd6;

    pulse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             done_set;

    logic [WIDTH-1:0] out_reg;
    logic [CNT_W-1:0] pulse_len;
    logic             done;
    logic             irq_en;
    logic [31:0]      rd_next;

    logic             write;
    logic             busy;
    logic             trigger;
    logic [WIDTH-1:0] wd_pins;

    // Bits of writedata above WIDTH have no destination.
    logic             unused_writedata;
    assign unused_writedata = ^writedata;

    assign write   = chipselect & ~write_n;
    assign wd_pins = writedata[WIDTH-1:0];
    assign busy    = (state_q == ACTIVE);

    // A trigger with no pins or a zero length does nothing.
    assign trigger = write && (address == ADDR_PULSE) &&
                     (wd_pins != '0) && (pulse_len != '0);

    assign out_port = out_reg | (busy ? mask_q : '0);
    assign irq      = done & irq_en;

    // Pulse engine next state. A trigger takes priority over expiry, so a
    // retrigger on the final cycle extends the pulse and suppresses done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = ACTIVE;
                    cnt_d   = pulse_len;
                    mask_d  = wd_pins;
                end
            end
            ACTIVE: begin
                if (trigger) begin
                    cnt_d  = pulse_len;
                    mask_d = mask_q | wd_pins;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    mask_d   = '0;
                    done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    // Read mux; readdata is registered every cycle regardless of chipselect.
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: rd_next[WIDTH-1:0] = out_reg;
            ADDR_PULSE_LEN:                      rd_next[CNT_W-1:0] = pulse_len;
            ADDR_PULSE:                          rd_next[WIDTH-1:0] = busy ? mask_q : '0;
            ADDR_STATUS:                         rd_next[1:0]       = {done, busy};
            ADDR_CONTROL:                        rd_next[0]         = irq_en;
            default:                             rd_next            = '0;
        endcase
    end

    // Bus-visible registers. A done set on the same edge as a STATUS write
    // wins so that a completion is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg   <= RESET_VALUE;
            pulse_len <= '0;
            done      <= 1'b0;
            irq_en    <= 1'b0;
            readdata  <= '0;
        end else begin
            readdata <= rd_next;
            if (write) begin
                case (address)
                    ADDR_DATA:      out_reg   <= wd_pins;
                    ADDR_OUTSET:    out_reg   <= out_reg | wd_pins;
                    ADDR_OUTCLR:    out_reg   <= out_reg & ~wd_pins;
                    ADDR_PULSE_LEN: pulse_len <= writedata[CNT_W-1:0];
                    ADDR_CONTROL:   irq_en    <= writedata[0];
                    default:        ;
                endcase
            end
            if (done_set) begin
                done <= 1'b1;
            end else if (write && (address == ADDR_STATUS)) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_pio_out_pulse.sv
// tb_core_pio_out_pulse
//
// Directed self-checking bench for core_pio_out_pulse with default
// parameters (WIDTH=10, CNT_W=16, RESET_VALUE=0). Inputs change 1 ns after
// the rising edge and outputs are sampled there too, so each applyStimulus
// or tick call advances exactly one clock edge.

module tb_core_pio_out_pulse;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [9:0]  out_port;

    int total;
    int bad;
    logic [31:0] rd;

    core_pio_out_pulse dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus write that takes effect on the next rising edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Idle cycle with the read mux pointed at addr; readdata afterwards
    // shows that register as it was before this edge.
    task automatic tick(input logic [2:0] addr);
        address    = addr;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        #1;
        checkOutput("reset_out_port", {22'b0, out_port}, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        checkOutput("reset_readdata", readdata, 32'h0);
        #25;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        readReg(3'd0, rd); checkOutput("rst_rd_data", rd, 32'h0);
        readReg(3'd3, rd); checkOutput("rst_rd_len", rd, 32'h0);
        readReg(3'd4, rd); checkOutput("rst_rd_pulse", rd, 32'h0);
        readReg(3'd5, rd); checkOutput("rst_rd_status", rd, 32'h0);
        readReg(3'd6, rd); checkOutput("rst_rd_control", rd, 32'h0);
        readReg(3'd7, rd); checkOutput("rst_rd_reserved", rd, 32'h0);

        // Set / clear
        applyStimulus(3'd0, 32'h0F0);
        checkOutput("data_write", {22'b0, out_port}, 32'h0F0);
        applyStimulus(3'd1, 32'h301);
        checkOutput("outset", {22'b0, out_port}, 32'h3F1);
        applyStimulus(3'd2, 32'h010);
        checkOutput("outclr", {22'b0, out_port}, 32'h3E1);
        readReg(3'd1, rd); checkOutput("rd_outset", rd, 32'h3E1);
        applyStimulus(3'd7, 32'hFFFF_FFFF);
        checkOutput("reserved_write_ignored", {22'b0, out_port}, 32'h3E1);

        // Pulse of 5 cycles on bit 2
        applyStimulus(3'd3, 32'd5);
        readReg(3'd3, rd); checkOutput("rd_pulse_len", rd, 32'd5);
        applyStimulus(3'd4, 32'h004);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("pulse5_high_%0d", i), {22'b0, out_port}, 32'h3E5);
            tick((i == 0) ? 3'd4 : 3'd5);
            if (i == 0)
                checkOutput("pulse5_rd_mask", readdata, 32'h004);
            else
                checkOutput($sformatf("pulse5_busy_%0d", i), readdata, 32'h1);
        end
        checkOutput("pulse5_low_after", {22'b0, out_port}, 32'h3E1);
        tick(3'd5);
        checkOutput("pulse5_done", readdata, 32'h2);
        checkOutput("irq_masked_done", {31'b0, irq}, 32'h0);
        readReg(3'd4, rd); checkOutput("rd_pulse_idle", rd, 32'h0);

        // Pulse of 1 cycle
        applyStimulus(3'd5, 32'h0);
        applyStimulus(3'd3, 32'd1);
        applyStimulus(3'd4, 32'h004);
        checkOutput("pulse1_high", {22'b0, out_port}, 32'h3E5);
        tick(3'd5);
        checkOutput("pulse1_low", {22'b0, out_port}, 32'h3E1);
        checkOutput("pulse1_busy", readdata, 32'h1);
        tick(3'd5);
        checkOutput("pulse1_done", readdata, 32'h2);

        // Null triggers: zero mask, then zero length
        applyStimulus(3'd5, 32'h0);
        applyStimulus(3'd4, 32'h0);
        checkOutput("null_mask", {22'b0, out_port}, 32'h3E1);
        applyStimulus(3'd3, 32'd0);
        applyStimulus(3'd4, 32'h004);
        checkOutput("null_len", {22'b0, out_port}, 32'h3E1);
        tick(3'd5);
        tick(3'd5);
        checkOutput("null_status", readdata, 32'h0);

        // Retrigger exactly on the expiry edge
        applyStimulus(3'd0, 32'h100);
        applyStimulus(3'd3, 32'd4);
        applyStimulus(3'd4, 32'h001);
        checkOutput("retrig_first", {22'b0, out_port}, 32'h101);
        for (int i = 1; i < 4; i++) begin
            tick(3'd5);
            checkOutput($sformatf("retrig_pre_%0d", i), {22'b0, out_port}, 32'h101);
            checkOutput($sformatf("retrig_pre_st_%0d", i), readdata, 32'h1);
        end
        applyStimulus(3'd4, 32'h002);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("retrig_ext_%0d", i), {22'b0, out_port}, 32'h103);
            tick(3'd5);
            checkOutput($sformatf("retrig_ext_st_%0d", i), readdata, 32'h1);
        end
        checkOutput("retrig_end", {22'b0, out_port}, 32'h100);
        tick(3'd5);
        checkOutput("retrig_done", readdata, 32'h2);

        // Interrupt, with STATUS clear colliding with expiry
        applyStimulus(3'd5, 32'h0);
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
        applyStimulus(3'd6, 32'h1);
        readReg(3'd6, rd); checkOutput("rd_control", rd, 32'h1);
        applyStimulus(3'd3, 32'd2);
        applyStimulus(3'd4, 32'h008);
        checkOutput("irq_pulse_high", {22'b0, out_port}, 32'h108);
        tick(3'd5);
        checkOutput("irq_before_end", {31'b0, irq}, 32'h0);
        applyStimulus(3'd5, 32'h0);
        checkOutput("irq_set_wins", {31'b0, irq}, 32'h1);
        checkOutput("irq_pulse_low", {22'b0, out_port}, 32'h100);
        readReg(3'd5, rd); checkOutput("irq_status_done", rd, 32'h2);
        applyStimulus(3'd5, 32'h0);
        checkOutput("irq_status_clear", {31'b0, irq}, 32'h0);

        // Masking irq keeps done
        applyStimulus(3'd4, 32'h008);
        tick(3'd5);
        tick(3'd5);
        checkOutput("irq_again", {31'b0, irq}, 32'h1);
        applyStimulus(3'd6, 32'h0);
        checkOutput("irq_masked", {31'b0, irq}, 32'h0);
        readReg(3'd5, rd); checkOutput("mask_keeps_done", rd, 32'h2);

        // Asynchronous reset in the middle of an 8-cycle pulse
        applyStimulus(3'd3, 32'd8);
        applyStimulus(3'd4, 32'h020);
        checkOutput("ar_pulse_high", {22'b0, out_port}, 32'h120);
        tick(3'd5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ar_out_immediate", {22'b0, out_port}, 32'h0);
        checkOutput("ar_readdata", readdata, 32'h0);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        readReg(3'd5, rd); checkOutput("ar_status", rd, 32'h0);
        tick(3'd4);
        tick(3'd4);
        checkOutput("ar_no_residual", {22'b0, out_port}, 32'h0);
        checkOutput("ar_rd_pulse", readdata, 32'h0);
        readReg(3'd3, rd); checkOutput("ar_len_cleared", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_pio_out_pulse.md
Name: core_pio_out_pulse

Overview:
- Avalon-MM slave output PIO: the driving counterpart of the system's input/edge-capture PIOs.
- Holds a WIDTH-bit output register with atomic set/clear access.
- Adds a hardware one-shot pulse engine: selected pins go high for a programmed number of clk cycles.
- Raises a maskable completion interrupt when a pulse ends. Sits on the Nios II data bus and drives LEDs, strobes and handshake lines.

Parameters:
WIDTH, 10, number of output pins (1..32)
CNT_W, 16, width of pulse-length register and down-counter (1..32)
RESET_VALUE, 0, value of out_reg after reset

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe (write = chipselect & ~write_n)
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  pulse-done interrupt
out_port  out  WIDTH  output pins

Behaviour:
- Reset (async, reset_n=0):
  - out_reg=RESET_VALUE; pulse_len=0; pulse_mask=0; cnt=0; busy=0; done=0; irq_en=0; readdata=0.
  - Reset mid-pulse aborts the pulse immediately; out_port=RESET_VALUE while reset is held.
- out_port = out_reg | (busy ? pulse_mask : 0). Combinational from registers, no extra latency.
- Address map (writes take effect on the clk edge where write=1):
  - 0 DATA: W out_reg<=wd[WIDTH-1:0]; R out_reg.
  - 1 OUTSET: W out_reg<=out_reg|wd; R out_reg.
  - 2 OUTCLR: W out_reg<=out_reg&~wd; R out_reg.
  - 3 PULSE_LEN: W pulse_len<=wd[CNT_W-1:0]; R pulse_len.
  - 4 PULSE: W trigger (below); R pulse_mask gated by busy (0 when idle).
  - 5 STATUS: R {30'b0, done, busy}; W any value clears done.
  - 6 CONTROL: W irq_en<=wd[0]; R {31'b0, irq_en}.
  - 7: R 0; writes ignored.
- readdata:
  - Registered every cycle from the address mux, regardless of chipselect.
  - Data for an address presented at edge E appears after E (1-cycle read latency).
  - Unused upper bits are 0. Reads have no side effects.
- Pulse engine, two states IDLE (busy=0) and ACTIVE (busy=1):
  - Trigger: write to address 4 with wd[WIDTH-1:0]!=0 and pulse_len!=0.
    - cnt<=pulse_len; busy<=1.
    - pulse_mask<=wd | (busy ? pulse_mask : 0). Retrigger while ACTIVE ORs in new bits and restarts the count.
  - Write to address 4 with zero mask or pulse_len==0: no effect, no done.
  - ACTIVE without trigger: cnt<=cnt-1. On the edge where cnt==1: busy<=0, pulse_mask<=0, done<=1 → IDLE.
  - Result: pins are high for exactly pulse_len cycles, starting the cycle after the trigger edge.
  - pulse_len = 2^CNT_W-1 is legal; no wrap occurs because the counter stops at expiry.
- Simultaneous events:
  - Trigger on the expiry edge: trigger wins; busy stays 1, cnt reloads, done not set.
  - STATUS write on the same edge done is set: set wins (done=1).
  - PULSE_LEN write while ACTIVE: affects only the next trigger.
  - DATA/OUTSET/OUTCLR writes while ACTIVE: update out_reg only; pulse bits remain ORed in.
- irq = done & irq_en (combinational from registers). Clearing irq_en masks irq without clearing done.

Test Plan:
- Reset/register access: after reset, read addresses 0,3,4,5,6 → 0 with 1-cycle latency; out_port=0.
- Set/clear: write DATA=0x0F0, OUTSET=0x301, OUTCLR=0x010 → out_port=0x3E1; read addr 1 → 0x3E1.
- Pulse length: PULSE_LEN=5, PULSE=0x004 → out_port[2] high exactly 5 cycles; busy=1 during; then done=1, busy=0. Repeat with PULSE_LEN=1 → 1 cycle.
- Retrigger/collision: PULSE_LEN=4, PULSE=0x001, then PULSE=0x002 exactly on the expiry edge → mask 0x003 held 4 more cycles, done set only once at the end. Also: PULSE=0 and PULSE with PULSE_LEN=0 → no pulse, done stays 0.
- Interrupt: CONTROL=1, complete a pulse → irq=1. STATUS write on the same edge as expiry → done stays 1. Later STATUS write → irq=0. With CONTROL=0 and done=1 → irq=0.
- Async reset mid-pulse: assert reset_n=0 at cycle 2 of an 8-cycle pulse → out_port=RESET_VALUE immediately, busy=0; after release no residual pulse and done=0.
